rf_write_arbiter: RTL and testbench

- Shares the register file's single write port (rfw_enable / rfw_address3 / rfw_data3) between N_REQ writeback sources, e.g. ALU, load unit and mult/div unit.
- Uses round-robin arbitration with a valid/ready handshake per source.
- The granted write is registered into an output stage that drives the register file directly; throughput is one write per cycle.
- Sits between the execute/memory writeback sources and the register file.

---
 rtl/rf_write_arbiter.sv | 128 ++++++++++++
 tb/tb_rf_write_arbiter.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rf_write_arbiter.sv
// Round-robin arbiter sharing the register file write port among N_REQ writeback sources.
// Optional read-port bypass from the output stage is enabled with `define RF_ARB_BYPASS_EN.
module rf_write_arbiter #(
  parameter int N_REQ  = 3,
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      wb_stall,
  input  logic [N_REQ-1:0]          req_valid,
  input  logic [N_REQ*ADDR_W-1:0]   req_addr,
  input  logic [N_REQ*DATA_W-1:0]   req_data,
  output logic [N_REQ-1:0]          req_ready,
  output logic                      rfw_enable,
  output logic [ADDR_W-1:0]         rfw_address3,
  output logic [DATA_W-1:0]         rfw_data3,
  output logic [2:0]                grant_id
`ifdef RF_ARB_BYPASS_EN
  ,
  input  logic [ADDR_W-1:0]         byp_raddr1,
  input  logic [ADDR_W-1:0]         byp_raddr2,
  output logic                      byp_hit1,
  output logic                      byp_hit2,
  output logic [DATA_W-1:0]         byp_data
`endif
);

  logic [2:0]        rr_ptr_q,       rr_ptr_d;
  logic              rfw_enable_q,   rfw_enable_d;
  logic [ADDR_W-1:0] rfw_address3_q, rfw_address3_d;
  logic [DATA_W-1:0] rfw_data3_q,    rfw_data3_d;
  logic [2:0]        grant_id_q,     grant_id_d;

  logic              gnt_vld;
  logic [2:0]        gnt_idx;
  logic [2:0]        cand;
  logic [7:0]        valid_pad;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_data;

  // Index base+off reduced modulo N_REQ; base is always < N_REQ, off <= N_REQ-1.
  function automatic logic [2:0] wrap_idx(input logic [2:0] base, input int off);
    int s;
    s = int'(base) + off;
    return (s >= N_REQ) ? 3'(s - N_REQ) : 3'(s);
  endfunction

  // Round-robin search starting at rr_ptr; nothing is granted while stalled.
  always_comb begin
    gnt_vld   = 1'b0;
    gnt_idx   = 3'd0;
    cand      = 3'd0;
    valid_pad = 8'(req_valid);
    for (int k = 0; k < N_REQ; k++) begin
      cand = wrap_idx(rr_ptr_q, k);
      if (!gnt_vld && !wb_stall && valid_pad[cand]) begin
        gnt_vld = 1'b1;
        gnt_idx = cand;
      end else begin
        gnt_vld = gnt_vld;
      end
    end
  end

  // One-hot ready plus selection of the granted source's address and data.
  always_comb begin
    req_ready = {N_REQ{1'b0}};
    sel_addr  = {ADDR_W{1'b0}};
    sel_data  = {DATA_W{1'b0}};
    for (int i = 0; i < N_REQ; i++) begin
      if (gnt_vld && (gnt_idx == 3'(i))) begin
        req_ready[i] = 1'b1;
        sel_addr     = req_addr[i*ADDR_W +: ADDR_W];
        sel_data     = req_data[i*DATA_W +: DATA_W];
      end else begin
        req_ready[i] = 1'b0;
      end
    end
  end

  // Output-stage and pointer next state; register 0 writes are accepted but never enabled.
  always_comb begin
    rfw_enable_d   = 1'b0;
    rfw_address3_d = rfw_address3_q;
    rfw_data3_d    = rfw_data3_q;
    grant_id_d     = grant_id_q;
    rr_ptr_d       = rr_ptr_q;
    if (gnt_vld) begin
      rfw_enable_d   = (sel_addr != {ADDR_W{1'b0}});
      rfw_address3_d = sel_addr;
      rfw_data3_d    = sel_data;
      grant_id_d     = gnt_idx;
      rr_ptr_d       = wrap_idx(gnt_idx, 1);
    end else begin
      rfw_enable_d   = 1'b0;
    end
  end

  // State registers; async reset discards any in-flight write immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q       <= 3'd0;
      rfw_enable_q   <= 1'b0;
      rfw_address3_q <= {ADDR_W{1'b0}};
      rfw_data3_q    <= {DATA_W{1'b0}};
      grant_id_q     <= 3'd0;
    end else begin
      rr_ptr_q       <= rr_ptr_d;
      rfw_enable_q   <= rfw_enable_d;
      rfw_address3_q <= rfw_address3_d;
      rfw_data3_q    <= rfw_data3_d;
      grant_id_q     <= grant_id_d;
    end
  end

  assign rfw_enable   = rfw_enable_q;
  assign rfw_address3 = rfw_address3_q;
  assign rfw_data3    = rfw_data3_q;
  assign grant_id     = grant_id_q;

`ifdef RF_ARB_BYPASS_EN
  assign byp_hit1 = rfw_enable_q && (rfw_address3_q == byp_raddr1) && (byp_raddr1 != {ADDR_W{1'b0}});
  assign byp_hit2 = rfw_enable_q && (rfw_address3_q == byp_raddr2) && (byp_raddr2 != {ADDR_W{1'b0}});
  assign byp_data = rfw_data3_q;
`endif

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Testbench for rf_write_arbiter: directed scenarios, then random traffic checked by a scoreboard.
module tb_rf_write_arbiter;
  localparam int N  = 3;
  localparam int AW = 5;
  localparam int DW = 32;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            wb_stall = 1'b0;
  logic [N-1:0]    req_valid = '0;
  logic [N*AW-1:0] req_addr = '0;
  logic [N*DW-1:0] req_data = '0;
  logic [N-1:0]    req_ready;
  logic            rfw_enable;
  logic [AW-1:0]   rfw_address3;
  logic [DW-1:0]   rfw_data3;
  logic [2:0]      grant_id;
`ifdef RF_ARB_BYPASS_EN
  logic [AW-1:0]   byp_raddr1 = '0;
  logic [AW-1:0]   byp_raddr2 = '0;
  logic            byp_hit1, byp_hit2;
  logic [DW-1:0]   byp_data;
`endif

  rf_write_arbiter #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst_n(rst_n), .wb_stall(wb_stall),
    .req_valid(req_valid), .req_addr(req_addr), .req_data(req_data),
    .req_ready(req_ready), .rfw_enable(rfw_enable), .rfw_address3(rfw_address3),
    .rfw_data3(rfw_data3), .grant_id(grant_id)
`ifdef RF_ARB_BYPASS_EN
    , .byp_raddr1(byp_raddr1), .byp_raddr2(byp_raddr2),
    .byp_hit1(byp_hit1), .byp_hit2(byp_hit2), .byp_data(byp_data)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    int            g;
  } wr_t;

  int  checks = 0;
  int  failures = 0;
  bit  mon_en = 1'b0;
  wr_t exp_q[$];
  wr_t srcq[N][$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic set_src(input int i, input logic v, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_valid[i]          = v;
    req_addr[i*AW +: AW]  = a;
    req_data[i*DW +: DW]  = d;
  endtask

  // Monitor: every enabled write must match the oldest expected write.
  always @(negedge clk) begin
    if (mon_en && rst_n && rfw_enable) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL sb_unexpected_write: actual addr=0x%0h required=no write", rfw_address3);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        chk("sb_addr", 64'(rfw_address3), 64'(e.a));
        chk("sb_data", 64'(rfw_data3), 64'(e.d));
        chk("sb_gid", 64'(grant_id), 64'(e.g));
      end
    end
  end

  int          ptr;
  logic [AW-1:0] cur_a[N];
  logic [DW-1:0] cur_d[N];

  initial begin
    // Reset state
    #12;
    chk("rst_en", 64'(rfw_enable), 64'd0);
    chk("rst_addr", 64'(rfw_address3), 64'd0);
    chk("rst_data", 64'(rfw_data3), 64'd0);
    chk("rst_gid", 64'(grant_id), 64'd0);
    rst_n = 1'b1;
    step;

    // Single source 1 write
    set_src(1, 1'b1, 5'd5, 32'hDEADBEEF);
    #1 chk("t1_ready", 64'(req_ready), 64'b010);
    step;
    chk("t1_en", 64'(rfw_enable), 64'd1);
    chk("t1_addr", 64'(rfw_address3), 64'd5);
    chk("t1_data", 64'(rfw_data3), 64'hDEADBEEF);
    chk("t1_gid", 64'(grant_id), 64'd1);
    set_src(1, 1'b0, 5'd0, 32'd0);

    // Pointer is now 2: sources 0 and 2 resolve as 2 then 0
    set_src(0, 1'b1, 5'd11, 32'h0000_0B0B);
    set_src(2, 1'b1, 5'd12, 32'h0000_0C0C);
    #1 chk("ptr2_ready", 64'(req_ready), 64'b100);
    step;
    chk("ptr2_gid", 64'(grant_id), 64'd2);
    set_src(2, 1'b0, 5'd0, 32'd0);
    #1 chk("ptr0_ready", 64'(req_ready), 64'b001);
    step;
    chk("ptr0_gid", 64'(grant_id), 64'd0);
    set_src(0, 1'b0, 5'd0, 32'd0);

    // Pointer 1: lone source 2 brings it back to 0, then stall with 0 and 2 pending
    set_src(2, 1'b1, 5'd9, 32'h9999_0009);
    #1 chk("st_pre_ready", 64'(req_ready), 64'b100);
    step;
    wb_stall = 1'b1;
    set_src(0, 1'b1, 5'd4, 32'h4444_0004);
    set_src(2, 1'b1, 5'd6, 32'h6666_0006);
    #1 chk("st1_ready", 64'(req_ready), 64'b000);
    chk("st1_en", 64'(rfw_enable), 64'd1);
    chk("st1_gid", 64'(grant_id), 64'd2);
    step;
    chk("st2_en", 64'(rfw_enable), 64'd0);
    chk("st2_gid_hold", 64'(grant_id), 64'd2);
    chk("st2_addr_hold", 64'(rfw_address3), 64'd9);
    #1 chk("st2_ready", 64'(req_ready), 64'b000);
    step;
    chk("st3_en", 64'(rfw_enable), 64'd0);
    #1 chk("st3_ready", 64'(req_ready), 64'b000);
    step;
    wb_stall = 1'b0;
    #1 chk("st_rel0_ready", 64'(req_ready), 64'b001);
    step;
    chk("st_rel0_gid", 64'(grant_id), 64'd0);
    chk("st_rel0_addr", 64'(rfw_address3), 64'd4);
    set_src(0, 1'b0, 5'd0, 32'd0);
    #1 chk("st_rel2_ready", 64'(req_ready), 64'b100);
    step;
    chk("st_rel2_gid", 64'(grant_id), 64'd2);
    chk("st_rel2_data", 64'(rfw_data3), 64'h6666_0006);
    set_src(2, 1'b0, 5'd0, 32'd0);

    // All three sources continuously valid for 6 cycles from pointer 0
    for (int i = 0; i < N; i++) begin
      cur_a[i] = 5'(i + 1);
      cur_d[i] = $urandom;
      set_src(i, 1'b1, cur_a[i], cur_d[i]);
    end
    for (int c = 0; c < 6; c++) begin
      int g;
      g = c % N;
      #1 chk("rr_ready", 64'(req_ready), 64'(1 << g));
      step;
      chk("rr_en", 64'(rfw_enable), 64'd1);
      chk("rr_gid", 64'(grant_id), 64'(g));
      chk("rr_addr", 64'(rfw_address3), 64'(cur_a[g]));
      chk("rr_data", 64'(rfw_data3), 64'(cur_d[g]));
      cur_a[g] = 5'(16 + c);
      cur_d[g] = $urandom;
      set_src(g, 1'b1, cur_a[g], cur_d[g]);
    end
    for (int i = 0; i < N; i++) set_src(i, 1'b0, 5'd0, 32'd0);

    // Write to register 0 is accepted but suppressed
    set_src(0, 1'b1, 5'd0, 32'h12345678);
    #1 chk("r0_ready", 64'(req_ready), 64'b001);
    step;
    chk("r0_en", 64'(rfw_enable), 64'd0);
    chk("r0_gid", 64'(grant_id), 64'd0);
    set_src(0, 1'b0, 5'd0, 32'd0);

`ifdef RF_ARB_BYPASS_EN
    set_src(1, 1'b1, 5'd7, 32'hA5A5A5A5);
    byp_raddr1 = 5'd7;
    byp_raddr2 = 5'd0;
    #1 chk("byp_ready", 64'(req_ready), 64'b010);
    step;
    chk("byp_hit1", 64'(byp_hit1), 64'd1);
    chk("byp_hit2", 64'(byp_hit2), 64'd0);
    chk("byp_data", 64'(byp_data), 64'hA5A5A5A5);
    set_src(1, 1'b0, 5'd0, 32'd0);
    step;
    chk("byp_hit1_idle", 64'(byp_hit1), 64'd0);
`endif

    // Asynchronous reset mid-cycle drops the in-flight write at once
    set_src(1, 1'b1, 5'd3, 32'h3333_0003);
    step;
    chk("ar_pre_en", 64'(rfw_enable), 64'd1);
    set_src(1, 1'b0, 5'd0, 32'd0);
    #1 rst_n = 1'b0;
    #1 chk("ar_en", 64'(rfw_enable), 64'd0);
    chk("ar_gid", 64'(grant_id), 64'd0);
    for (int i = 0; i < N; i++) set_src(i, 1'b1, 5'(i + 20), 32'(i));
    #1 rst_n = 1'b1;
    #1 chk("ar_ready", 64'(req_ready), 64'b001);
    step;
    chk("ar_gid_after", 64'(grant_id), 64'd0);
    for (int i = 0; i < N; i++) set_src(i, 1'b0, 5'd0, 32'd0);

    // Random traffic against the reference model
    rst_n = 1'b0;
    #2 rst_n = 1'b1;
    step;
    ptr = 0;
    mon_en = 1'b1;
    for (int cyc = 0; cyc < 460; cyc++) begin
      int g;
      bit feed;
      feed = (cyc < 400);
      for (int i = 0; i < N; i++) begin
        if (feed && srcq[i].size() < 4 && $urandom_range(0, 9) < 4) begin
          wr_t w;
          w.a = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
          w.d = $urandom;
          w.g = i;
          srcq[i].push_back(w);
        end
        if (srcq[i].size() > 0) set_src(i, 1'b1, srcq[i][0].a, srcq[i][0].d);
        else set_src(i, 1'b0, 5'd0, 32'd0);
      end
      wb_stall = feed && ($urandom_range(0, 4) == 0);
      g = -1;
      if (!wb_stall) begin
        for (int k = 0; k < N; k++) begin
          if (g < 0 && srcq[(ptr + k) % N].size() > 0) g = (ptr + k) % N;
        end
      end
      #1 chk("rand_ready", 64'(req_ready), (g < 0) ? 64'd0 : 64'(1 << g));
      if (g >= 0) begin
        wr_t w;
        w = srcq[g].pop_front();
        if (w.a != 5'd0) exp_q.push_back(w);
        ptr = (g + 1) % N;
      end
      step;
    end
    for (int i = 0; i < N; i++) set_src(i, 1'b0, 5'd0, 32'd0);
    step;
    step;
    chk("drain_sb_empty", 64'(exp_q.size()), 64'd0);
    chk("drain_src_empty", 64'(srcq[0].size() + srcq[1].size() + srcq[2].size()), 64'd0);
    mon_en = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: actual=running required=finished");
    $fatal(1, "timeout");
  end
endmodule
